load_sched_ctrl: RTL and testbench
==================================

LOAD_SCHED_CTRL -- requirements
Module: load_sched_ctrl

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters sharing the loadable counter (fixed at 4 for this release).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req  input  4  per-requester request; bit i belongs to requester i.
REQ-005 SHALL have port req_val  input  16  per-requester 4-bit start value; bits [4i+3:4i] belong to requester i.
REQ-006 SHALL have port gnt  output  4  one-hot grant; all zeros when idle.
REQ-007 SHALL have port done  output  1  one-cycle pulse marking completion of the granted run.
REQ-008 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-009 SHALL have port cnt_load  output  1  load strobe for the shared counter, high for exactly the LOAD cycle.
REQ-010 SHALL have port cnt_load_val  output  4  value being loaded; valid while cnt_load is high.
REQ-011 SHALL have port count  output  4  shared 4-bit counter value.

Function
REQ-012 SHALL implement the FSM states IDLE, LOAD, RUN and DONE, with all outputs registered.
REQ-013 SHALL, in IDLE with any req bit high, grant one requester by round-robin, starting the search at pointer ptr and wrapping 3->0.
REQ-014 SHALL, on that grant, set gnt to the one-hot winner, latch its req_val into cnt_load_val and enter LOAD on the next edge.
REQ-015 SHALL ignore req_val changes after the grant; only the latched value is used.
REQ-016 SHALL, in LOAD, assert cnt_load, set count to cnt_load_val at the next edge and enter RUN.
REQ-017 SHALL, in RUN with count != 4'hF, increment count by 1 per cycle.
REQ-018 SHALL, in RUN with count == 4'hF, hold count (no wrap to 0) and enter DONE.
REQ-019 SHALL, in DONE, assert done for one cycle with gnt still held, then clear gnt, set ptr to (winner+1) mod 4 and return to IDLE.
REQ-020 SHALL treat a start value of 4'hF as one RUN cycle followed by DONE.
REQ-021 SHALL define latency for start value v as: req sampled in IDLE at edge 0; gnt and LOAD at edge 1; count=v at edge 2; done high in the cycle after edge 2+(15-v)+1.
REQ-022 SHALL, if the granted requester drops req during LOAD or RUN, abort: return to IDLE next edge, clear gnt, no done pulse, count holds, ptr advances past the aborted requester.
REQ-023 SHALL not re-arbitrate in DONE; a new grant is issued no earlier than the first IDLE cycle after DONE.
REQ-024 SHALL let count hold its value in IDLE.
REQ-025 SHALL keep gnt at most one-hot at all times.
REQ-026 SHALL ignore requests from non-granted requesters while busy; they wait and are not lost.

Reset
REQ-027 SHALL, on rst high at any time including mid-run, immediately force state=IDLE, gnt=0, done=0, busy=0, cnt_load=0, cnt_load_val=0, count=0 and ptr=0.
REQ-028 SHALL, after rst deasserts, arbitrate from requester 0 first.

Verification
REQ-029 SHALL verify single request: req=4'b0001 with val0=4'hC -> gnt=0001 at edge 1, count 12,13,14,15 on successive cycles, one done pulse, then gnt=0.
REQ-030 SHALL verify round-robin: req=4'b1111 held after reset -> grant order 0,1,2,3,0, each run completing with done.
REQ-031 SHALL verify boundary: val=4'hF -> LOAD, one RUN cycle, DONE; count never shows 0 after load.
REQ-032 SHALL verify abort: requester 2 drops req mid-RUN at count=7 -> IDLE next edge, no done, count stays 7, next grant goes to requester 3 if it is requesting.
REQ-033 SHALL verify reset mid-run: rst pulsed at count=9 -> all outputs 0 asynchronously; after release with req=4'b1010, requester 1 is granted first.

Source files
------------

// File: rtl/load_sched_ctrl.sv
// load_sched_ctrl: round-robin scheduler for a single shared 4-bit loadable
// counter. A granted requester loads its start value, the counter runs up to
// 4'hF, and the run ends with a one-cycle done pulse. Dropping the request
// mid-run aborts the run without a done pulse.
module load_sched_ctrl #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [4*NREQ-1:0]    req_val,
    output logic [NREQ-1:0]      gnt,
    output logic                 done,
    output logic                 busy,
    output logic                 cnt_load,
    output logic [3:0]           cnt_load_val,
    output logic [3:0]           count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;      // first requester to consider at the next grant
    logic [PW-1:0]   win;      // requester owning the current run
    logic            found;
    logic [PW-1:0]   pick;
    logic            owner_req;

    // Pointer value that starts the next search just past the given requester.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] w);
        if (int'(w) == NREQ - 1)
            return '0;
        else
            return w + 1'b1;
    endfunction

    // Round-robin search: first requesting index at or after ptr, wrapping.
    always_comb begin
        int j;
        found = 1'b0;
        pick  = ptr;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = PW'(j);
            end
        end
    end

    // The owner keeps its run alive only while it keeps requesting.
    assign owner_req = req[win];

    // Scheduler FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            win          <= '0;
            gnt          <= '0;
            done         <= 1'b0;
            busy         <= 1'b0;
            cnt_load     <= 1'b0;
            cnt_load_val <= 4'h0;
            count        <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (found) begin
                        // Start value is captured here; later req_val changes
                        // have no effect on this run.
                        gnt          <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                        win          <= pick;
                        cnt_load_val <= req_val[{pick, 2'b00} +: 4];
                        cnt_load     <= 1'b1;
                        busy         <= 1'b1;
                        state        <= LOAD;
                    end
                end

                LOAD: begin
                    cnt_load <= 1'b0;
                    if (!owner_req) begin
                        // Abort before the load takes effect: count untouched.
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= next_ptr(win);
                        state <= IDLE;
                    end else begin
                        count <= cnt_load_val;
                        state <= RUN;
                    end
                end

                RUN: begin
                    if (!owner_req) begin
                        // Abort wins over completion; count freezes where it is.
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= next_ptr(win);
                        state <= IDLE;
                    end else if (count == 4'hF) begin
                        // Saturate at 4'hF rather than wrapping.
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        count <= count + 4'h1;
                    end
                end

                DONE: begin
                    // No arbitration here; the next grant comes from IDLE.
                    done  <= 1'b0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    ptr   <= next_ptr(win);
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_sched_ctrl.sv
// Bench for load_sched_ctrl: directed scenarios plus randomized runs, each
// checked against a transaction-level model (winner choice, count sequence,
// done timing, pointer advance) computed from the scheduling rules.
module tb_load_sched_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0;
    logic [15:0] req_val = 16'h0;
    logic [3:0]  gnt;
    logic        done, busy, cnt_load;
    logic [3:0]  cnt_load_val, count;

    int total  = 0;
    int passed = 0;

    // Model state: round-robin pointer and the counter value the DUT should hold.
    int ptr_m   = 0;
    int count_m = 0;

    load_sched_ctrl #(.NREQ(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_val      (req_val),
        .gnt          (gnt),
        .done         (done),
        .busy         (busy),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    // Grant must never have more than one bit set.
    always @(negedge clk) begin
        if (!rst) chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    end

    // Winner: first requester at or after the model pointer, wrapping 3->0.
    function automatic int pick_m(input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
        end
        return -1;
    endfunction

    // One transaction from an IDLE start. mode 0: run to completion;
    // mode 1: owner drops request during LOAD; mode 2: owner drops request
    // in RUN once count reaches a value derived from off.
    task automatic do_run(input logic [3:0] r, input logic [15:0] vals,
                          input int mode, input int off);
        int w, v, c, ab;
        logic [3:0] drop;
        w  = pick_m(r);
        v  = int'((vals >> (4 * w)) & 16'hF);
        ab = -1;
        if (mode == 2 && v < 15) ab = v + (off % (15 - v));
        drop = r & ~(4'b0001 << w);
        req     = r;
        req_val = vals;
        @(posedge clk); #1;
        chk("grant",         32'(gnt),          32'(1 << w));
        chk("load_strobe",   32'(cnt_load),     32'd1);
        chk("load_val",      32'(cnt_load_val), 32'(v));
        chk("busy_grant",    32'(busy),         32'd1);
        chk("count_idle",    32'(count),        32'(count_m));
        req_val = 16'($urandom);
        if (mode == 1) begin
            req = drop;
            @(posedge clk); #1;
            chk("abort_ld_gnt",   32'(gnt),   32'd0);
            chk("abort_ld_busy",  32'(busy),  32'd0);
            chk("abort_ld_done",  32'(done),  32'd0);
            chk("abort_ld_count", 32'(count), 32'(count_m));
            ptr_m = (w + 1) % 4;
            return;
        end
        @(posedge clk); #1;
        chk("count_loaded", 32'(count),    32'(v));
        chk("load_off",     32'(cnt_load), 32'd0);
        chk("gnt_run",      32'(gnt),      32'(1 << w));
        c = v;
        for (int k = 0; k < 20; k++) begin
            if (c == ab) begin
                req = drop;
                @(posedge clk); #1;
                chk("abort_gnt",   32'(gnt),   32'd0);
                chk("abort_busy",  32'(busy),  32'd0);
                chk("abort_done",  32'(done),  32'd0);
                chk("abort_count", 32'(count), 32'(c));
                count_m = c;
                ptr_m   = (w + 1) % 4;
                return;
            end
            if (c == 15) begin
                @(posedge clk); #1;
                chk("done_pulse", 32'(done),  32'd1);
                chk("done_gnt",   32'(gnt),   32'(1 << w));
                chk("done_count", 32'(count), 32'd15);
                @(posedge clk); #1;
                chk("post_done",       32'(done),  32'd0);
                chk("post_done_gnt",   32'(gnt),   32'd0);
                chk("post_done_busy",  32'(busy),  32'd0);
                chk("post_done_count", 32'(count), 32'd15);
                count_m = 15;
                ptr_m   = (w + 1) % 4;
                return;
            end
            @(posedge clk); #1;
            c++;
            chk("count_run", 32'(count), 32'(c));
            chk("run_done0", 32'(done),  32'd0);
        end
        chk("run_bound", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_gnt",  32'(gnt),          32'd0);
        chk("rst_busy", 32'(busy),         32'd0);
        chk("rst_done", 32'(done),         32'd0);
        chk("rst_load", 32'(cnt_load),     32'd0);
        chk("rst_lval", 32'(cnt_load_val), 32'd0);
        chk("rst_cnt",  32'(count),        32'd0);
        #2;
        rst = 1'b0;
        ptr_m   = 0;
        count_m = 0;
    endtask

    initial begin
        int m, n;
        // Reset state with the clock running.
        #12;
        do_reset();
        @(posedge clk); #1;

        // Single request, start value 4'hC.
        do_run(4'b0001, 16'h000C, 0, 0);

        // Idle with no request: count holds, nothing granted.
        req = 4'b0000;
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_count", 32'(count), 32'(count_m));
            chk("idle_busy",  32'(busy),  32'd0);
        end

        // Round-robin with all four requesting after reset: 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 5; i++)
            do_run(4'b1111, 16'hFDEB, 0, 0);

        // Boundary start value 4'hF: one RUN cycle then DONE.
        req = 4'b0000;
        do_reset();
        do_run(4'b0001, 16'h000F, 0, 0);

        // Abort: requester 2 drops at count 7, requester 3 gets the next grant.
        req = 4'b0000;
        do_reset();
        do_run(4'b1100, 16'h0300, 2, 4);
        do_run(4'b1000, 16'hA000, 0, 0);

        // Abort during LOAD.
        do_run(4'b0010, 16'h0050, 1, 0);

        // Reset mid-run at count 9, then requester 1 first out of 4'b1010.
        req     = 4'b0001;
        req_val = 16'h0005;
        n = 0;
        while (n < 30 && !(busy && !cnt_load && count == 4'd9)) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_9", 32'(count), 32'd9);
        req = 4'b0000;
        do_reset();
        do_run(4'b1010, 16'h0E0E, 0, 0);

        // Randomized runs back to back.
        for (int i = 0; i < 14; i++) begin
            m = int'($urandom_range(0, 3));
            do_run(4'($urandom_range(1, 15)), 16'($urandom),
                   (m == 3) ? 2 : ((m == 2) ? 1 : 0), int'($urandom_range(0, 14)));
        end

        req = 4'b0000;
        @(posedge clk); #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
